// File: rtl/vip_video_stream_gen.sv
// Test-pattern video timing generator: VSYNC/VBP/ACTIVE/VFP framing with ramp, checker and flat patterns.
// Optional `VIP_GEN_FRAME_XOR_EN` XORs each pixel with a per-frame counter.
module vip_video_stream_gen #(
  parameter int IMG_HDISP   = 640,
  parameter int IMG_VDISP   = 480,
  parameter int H_BLANK     = 160,
  parameter int VSYNC_LINES = 2,
  parameter int VBP_LINES   = 33,
  parameter int VFP_LINES   = 10,
  parameter int CLK_DIV     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gen_en,
  input  logic [1:0]  pattern_sel,
  input  logic [7:0]  const_gray,
  output logic        per_frame_vsync,
  output logic        per_frame_href,
  output logic        per_frame_clken,
  output logic [23:0] per_img_Gray,
  output logic        busy,
  output logic        frame_done
);
  localparam int H_TOTAL = IMG_HDISP + H_BLANK;
  localparam int V_TOTAL = VSYNC_LINES + VBP_LINES + IMG_VDISP + VFP_LINES;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int DW = $clog2(CLK_DIV + 1);

  typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, VFP} state_t;

  state_t         state_reg, state_next;
  logic [HW-1:0]  h_cnt_reg, h_cnt_next;
  logic [VW-1:0]  v_cnt_reg, v_cnt_next;
  logic [DW-1:0]  div_cnt_reg, div_cnt_next;
  logic [1:0]     pat_reg, pat_next;
  logic [7:0]     gray_reg, gray_next;
  logic           tick, line_end, region_end, frame_end, frame_start;
  logic           href_next, clken_next;
  int             region_len;
  logic [7:0]     x8, y8, g;
  logic [23:0]    gray_rep;

  // First region at or after s that has a nonzero line count; IDLE means the frame is over.
  function automatic state_t skip_from(input state_t s);
    state_t r;
    r = IDLE;
    if (s == VSYNC && VSYNC_LINES > 0)
      r = VSYNC;
    else if ((s == VSYNC || s == VBP) && VBP_LINES > 0)
      r = VBP;
    else if (s != VFP && IMG_VDISP > 0)
      r = ACTIVE;
    else if (VFP_LINES > 0)
      r = VFP;
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      h_cnt_reg   <= '0;
      v_cnt_reg   <= '0;
      div_cnt_reg <= '0;
      pat_reg     <= '0;
      gray_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      h_cnt_reg   <= h_cnt_next;
      v_cnt_reg   <= v_cnt_next;
      div_cnt_reg <= div_cnt_next;
      pat_reg     <= pat_next;
      gray_reg    <= gray_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    h_cnt_next   = h_cnt_reg;
    v_cnt_next   = v_cnt_reg;
    div_cnt_next = div_cnt_reg;
    pat_next     = pat_reg;
    gray_next    = gray_reg;
    frame_end    = 1'b0;
    frame_start  = 1'b0;
    region_len   = 0;
    case (state_reg)
      VSYNC:   region_len = VSYNC_LINES;
      VBP:     region_len = VBP_LINES;
      ACTIVE:  region_len = IMG_VDISP;
      VFP:     region_len = VFP_LINES;
      default: region_len = 0;
    endcase
    tick       = (32'(div_cnt_reg) == CLK_DIV - 1);
    line_end   = tick && (32'(h_cnt_reg) == H_TOTAL - 1);
    region_end = line_end && (32'(v_cnt_reg) == region_len - 1);

    if (state_reg == IDLE) begin
      frame_start = gen_en;
    end else begin
      if (tick) begin
        div_cnt_next = '0;
        h_cnt_next   = line_end ? '0 : h_cnt_reg + HW'(1);
      end else begin
        div_cnt_next = div_cnt_reg + DW'(1);
      end
      if (line_end)
        v_cnt_next = region_end ? '0 : v_cnt_reg + VW'(1);
      if (region_end) begin
        case (state_reg)
          VSYNC:   state_next = skip_from(VBP);
          VBP:     state_next = skip_from(ACTIVE);
          ACTIVE:  state_next = skip_from(VFP);
          default: state_next = IDLE;
        endcase
        if (state_next == IDLE) begin
          frame_end   = 1'b1;
          frame_start = gen_en;
        end
      end
    end

    // A new frame restarts the counters and re-latches the pattern controls.
    if (frame_start) begin
      state_next   = skip_from(VSYNC);
      h_cnt_next   = '0;
      v_cnt_next   = '0;
      div_cnt_next = '0;
      pat_next     = pattern_sel;
      gray_next    = const_gray;
    end
  end

`ifdef VIP_GEN_FRAME_XOR_EN
  logic [7:0] frame_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst)
      frame_cnt_reg <= '0;
    else if (frame_end)
      frame_cnt_reg <= frame_cnt_reg + 8'd1;
  end
`endif

  always_comb begin
    x8 = 8'(h_cnt_reg);
    y8 = 8'(v_cnt_reg);
    case (pat_reg)
      2'd0:    g = x8;
      2'd1:    g = y8;
      2'd2:    g = (x8[3] ^ y8[3]) ? 8'hFF : 8'h00;
      default: g = gray_reg;
    endcase
`ifdef VIP_GEN_FRAME_XOR_EN
    g = g ^ frame_cnt_reg;
`endif
    href_next  = (state_reg == ACTIVE) && (32'(h_cnt_reg) < IMG_HDISP);
    clken_next = href_next && tick;
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_rep
    assign gray_rep[gi*8 +: 8] = g;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      per_frame_vsync <= 1'b0;
      per_frame_href  <= 1'b0;
      per_frame_clken <= 1'b0;
      per_img_Gray    <= '0;
      busy            <= 1'b0;
      frame_done      <= 1'b0;
    end else begin
      per_frame_vsync <= (state_reg == VSYNC);
      per_frame_href  <= href_next;
      per_frame_clken <= clken_next;
      per_img_Gray    <= clken_next ? gray_rep : 24'd0;
      busy            <= (state_reg != IDLE);
      frame_done      <= frame_end;
    end
  end

endmodule

// File: tb/tb_vip_video_stream_gen.sv
// Scoreboard bench: two generator configurations share random stimulus; a cycle-index frame model
// predicts framing signals and queues expected pixels, and per-instance monitors compare on clken.
module tb_vip_video_stream_gen;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       gen_en = 1'b0;
  logic [1:0] pattern_sel = 2'd0;
  logic [7:0] const_gray = 8'd0;
  int         n_checks = 0;
  int         n_fail = 0;
  bit         end_chk = 1'b0;

`ifdef VIP_GEN_FRAME_XOR_EN
  localparam bit XOR_EN = 1'b1;
`else
  localparam bit XOR_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic check(input string name, input int cfg, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cfg%0d t=%0t got %0h expected %0h", name, cfg, $time, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_gray(input int p, input int x, input int y, input logic [7:0] cg);
    case (p)
      0:       return 8'(x % 256);
      1:       return 8'(y % 256);
      2:       return (((x / 8) % 2) != ((y / 8) % 2)) ? 8'hFF : 8'h00;
      default: return cg;
    endcase
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
    localparam int HD  = (gi == 0) ? 4 : 16;
    localparam int VD  = (gi == 0) ? 3 : 16;
    localparam int HB  = 2;
    localparam int LV  = 1;
    localparam int LB  = 1;
    localparam int LF  = 1;
    localparam int D   = (gi == 0) ? 1 : 3;
    localparam int HTD = (HD + HB) * D;
    localparam int T   = (LV + LB + VD + LF) * HTD;

    logic        vs, href, clken, busy, done;
    logic [23:0] data;
    logic [31:0] pix_q[$];
    bit          run = 1'b0;
    int          cyc = 0;
    int          frames = 0;
    logic [7:0]  fcnt = 8'd0;
    bit          e_vs = 1'b0, e_href = 1'b0, e_clk = 1'b0, e_busy = 1'b0, e_done = 1'b0;

    vip_video_stream_gen #(
      .IMG_HDISP(HD), .IMG_VDISP(VD), .H_BLANK(HB),
      .VSYNC_LINES(LV), .VBP_LINES(LB), .VFP_LINES(LF), .CLK_DIV(D)
    ) dut (
      .clk(clk), .rst(rst), .gen_en(gen_en), .pattern_sel(pattern_sel), .const_gray(const_gray),
      .per_frame_vsync(vs), .per_frame_href(href), .per_frame_clken(clken),
      .per_img_Gray(data), .busy(busy), .frame_done(done)
    );

    // Reference model: the frame is a run of T cycles; outputs lag the frame position by one cycle.
    initial forever begin
      @(posedge clk);
      if (rst) begin
        run = 1'b0;
        cyc = 0;
        fcnt = 8'd0;
        pix_q.delete();
        {e_vs, e_href, e_clk, e_busy, e_done} = 5'b0;
      end else begin
        int line, slot;
        logic [7:0] gv;
        line   = cyc / HTD;
        slot   = (cyc % HTD) / D;
        e_busy = run;
        e_vs   = run && (line < LV);
        e_href = run && (line >= LV + LB) && (line < LV + LB + VD) && (slot < HD);
        e_clk  = e_href && ((cyc % D) == D - 1);
        e_done = run && (cyc == T - 1);
        if (e_done) begin
          run  = 1'b0;
          fcnt = fcnt + 8'd1;
        end else if (run) begin
          cyc++;
        end
        if (!run && gen_en) begin
          run = 1'b1;
          cyc = 0;
          for (int y = 0; y < VD; y++)
            for (int x = 0; x < HD; x++) begin
              gv = ref_gray(int'(pattern_sel), x, y, const_gray) ^ (XOR_EN ? fcnt : 8'h00);
              pix_q.push_back({8'h00, gv, gv, gv});
            end
        end
      end
    end

    initial forever begin
      logic [31:0] exp_pix;
      @(negedge clk);
      check("vsync", gi, 32'(vs), 32'(e_vs));
      check("href", gi, 32'(href), 32'(e_href));
      check("clken", gi, 32'(clken), 32'(e_clk));
      check("busy", gi, 32'(busy), 32'(e_busy));
      check("frame_done", gi, 32'(done), 32'(e_done));
      if (clken) begin
        exp_pix = (pix_q.size() > 0) ? pix_q.pop_front() : 32'hDEAD_BEEF;
        check("pixel", gi, 32'(data), exp_pix);
      end else begin
        check("data_idle", gi, 32'(data), 32'd0);
      end
      if (done) begin
        frames++;
        $display("cfg%0d frame %0d done at %0t", gi, frames, $time);
      end
    end

    initial begin
      wait (end_chk);
      check("queue_empty", gi, 32'(pix_q.size()), 32'd0);
      check("idle_at_end", gi, 32'(busy), 32'd0);
    end
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    gen_en = 1'b1;
    pattern_sel = 2'd0;
    repeat (80) @(negedge clk);
    pattern_sel = 2'd1;
    repeat (40) @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      pattern_sel = 2'($urandom_range(0, 3));
      const_gray  = 8'($urandom);
      gen_en      = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      repeat ($urandom_range(1, 60)) @(negedge clk);
    end

    // Frame aligned by reset; gen_en dropped during the second active line of the small config.
    gen_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pattern_sel = 2'd0;
    gen_en = 1'b1;
    repeat (20) @(negedge clk);
    gen_en = 1'b0;
    repeat (60) @(negedge clk);

    // Reset in the middle of the active region with gen_en held high.
    gen_en = 1'b1;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);

    // Long frames for the wide, divided configuration: checkerboard, then constant 0x5A.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pattern_sel = 2'd2;
    gen_en = 1'b1;
    repeat (1100) @(negedge clk);
    pattern_sel = 2'd3;
    const_gray = 8'h5A;
    repeat (1100) @(negedge clk);
    gen_en = 1'b0;
    repeat (1200) @(negedge clk);

    end_chk = 1'b1;
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
